rc4_stream_ctrl: RTL
====================

Name: rc4_stream_ctrl

Overview:
- Sequencer wrapped around the RC4 keystream core.
- Per message: re-keys the core (reset pulse, key load, start), throttles keystream production into a small FIFO, and XORs keystream with a plaintext byte stream under valid/ready handshakes.
- Counts bytes and signals completion; one message in flight at a time.

Parameters:
FIFO_DEPTH, 8, keystream buffer depth in bytes; power of two, 4..64.
DROP_N, 256, keystream bytes discarded after key schedule; used only when RC4_DROP_EN is defined.

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
cfg_key  input  32  RC4 key, byte 0 = [7:0]; sampled on accepted cmd_start
cfg_key_len  input  8  key length in bytes; legal 1..4; sampled on accepted cmd_start
cfg_msg_len  input  16  message length in bytes; sampled on accepted cmd_start
cmd_start  input  1  start pulse; ignored while busy=1
busy  output  1  high from accepted start until done
done  output  1  one-cycle completion pulse
err  output  1  sticky error flag; cleared on next accepted start
s_valid  input  1  plaintext byte valid
s_ready  output  1  plaintext byte accepted when s_valid&s_ready
s_data  input  8  plaintext byte
m_valid  output  1  ciphertext byte valid
m_ready  input  1  downstream ready
m_data  output  8  ciphertext byte
core_rst_n  output  1  synchronous active-low reset to core
core_start  output  1  core start level
core_key  output  32  latched key to core
core_key_len  output  8  latched key length to core
core_ks_en  output  1  core may emit next keystream byte
core_ks_valid  input  1  keystream byte valid, 1-cycle strobe
core_ks_byte  input  8  keystream byte

Behaviour:
- Reset values: busy=0, done=0, err=0, s_ready=0, m_valid=0, m_data=0, core_rst_n=0, core_start=0, core_ks_en=0, core_key=0, core_key_len=0; FIFO empty; all counters 0; state IDLE.
- rst asserted mid-message aborts immediately; no done pulse; in-flight bytes are lost.
- IDLE:
  - On cmd_start, latch cfg_*, clear err, set busy.
  - cfg_key_len==0 or >4: err=1 and done pulse in the next cycle; core untouched; return to IDLE.
  - cfg_msg_len==0: done pulse in the next cycle; core untouched.
  - Otherwise go to CORE_RST.
  - core_rst_n is held 1 in IDLE outside reset.
- CORE_RST: core_rst_n=0 for exactly 2 cycles; FIFO flushed; gen_cnt and out_cnt cleared; then go to KEYSCHED.
- KEYSCHED: core_start=1 until the first core_ks_valid; then go to STREAM. No timeout.
- STREAM:
  - core_ks_en = (fifo_count < FIFO_DEPTH-1) && (gen_cnt < msg_len). The FIFO_DEPTH-1 threshold covers the core's 1-cycle enable-to-strobe latency.
  - Each core_ks_valid pushes core_ks_byte and increments gen_cnt.
  - A strobe arriving when FIFO is full or gen_cnt==msg_len is dropped and sets err=1; the message continues.
  - s_ready = !fifo_empty && (!m_valid || m_ready) && (in_cnt < msg_len).
  - On s fire: m_data <= s_data ^ fifo_head; m_valid <= 1; pop; in_cnt++. Latency: one cycle from s fire to m_valid.
  - m_valid holds with m_data stable until m_ready. Back-to-back fires sustain 1 byte/cycle.
  - When in_cnt==msg_len, go to DRAIN.
- DRAIN: s_ready=0, core_ks_en=0. When m_valid==0, or m_valid&&m_ready, go to FINISH.
- FINISH:
  - done=1 for one cycle; busy=0 the same cycle; core_start=0; FIFO flushed.
  - core_rst_n=0 for one cycle to park the core.
  - Return to IDLE; a new cmd_start is accepted the following cycle.
- Counters are 16-bit. msg_len=65535 must not wrap; comparisons are equality/less-than on 16 bits.
- Simultaneous push and pop in one cycle: fifo_count unchanged. Pop from an empty FIFO is impossible by construction of s_ready.

Optional Feature:
- Macro RC4_DROP_EN. When defined, a DROP state sits between KEYSCHED and STREAM.
  - core_ks_en=1 and each strobe is discarded (not pushed) until DROP_N bytes are counted.
  - The first byte that ends KEYSCHED counts as drop byte 1.
  - gen_cnt starts after the drops.
- When undefined: no DROP state; DROP_N is ignored; the first keystream byte is pushed.

Test Plan:
- Key 0x00000000 len 1, msg_len 4, plaintext 00 00 00 00 with m_ready=1 -> m_data equals the first 4 RC4 keystream bytes of key {00} (DE 18 89 41); done pulse once; busy low after.
- Key bytes 4B 65 79 ("Key"), cfg_key_len=3, plaintext "Plaintext" (9 bytes) -> ciphertext BB F3 16 E8 D9 40 AF 0A D3; one byte per cycle when s_valid=m_ready=1.
- Same as above with m_ready toggling 1/0 each cycle and s_valid random -> identical ciphertext; m_data stable while m_valid&&!m_ready; fifo_count never exceeds FIFO_DEPTH; err=0.
- cfg_key_len=5 -> err=1 and done one cycle after start; core_start never asserted. cfg_msg_len=0 -> done, err=0.
- rst asserted mid-STREAM after 3 bytes, then new start with a different key -> outputs at reset values during rst; second message correct from its byte 0.
- With RC4_DROP_EN, DROP_N=4, key "Key", plaintext 00 x2 -> m_data = keystream bytes 5..6 of key "Key".

Source files
------------

// File: rtl/rc4_stream_ctrl.sv
// rc4_stream_ctrl: per-message sequencer around an RC4 keystream core.
// Re-keys the core, buffers keystream in a small FIFO and XORs it with the
// plaintext stream under valid/ready handshakes.
// Optional feature macro: RC4_DROP_EN (discard the first DROP_N keystream bytes).
`timescale 1ns/1ps
module rc4_stream_ctrl #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned DROP_N     = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cfg_key,
   input  logic [7:0]  cfg_key_len,
   input  logic [15:0] cfg_msg_len,
   input  logic        cmd_start,
   output logic        busy,
   output logic        done,
   output logic        err,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [7:0]  s_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [7:0]  m_data,
   output logic        core_rst_n,
   output logic        core_start,
   output logic [31:0] core_key,
   output logic [7:0]  core_key_len,
   output logic        core_ks_en,
   input  logic        core_ks_valid,
   input  logic [7:0]  core_ks_byte
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] EN_LVL   = (AW+1)'(FIFO_DEPTH - 1);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

   if (FIFO_DEPTH < 4 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       DROP_N == 0 || DROP_N > 65535) begin : g_param_check
      $error("rc4_stream_ctrl: FIFO_DEPTH must be a power of two in 4..64, DROP_N in 1..65535");
   end

   typedef enum logic [2:0] {
      IDLE,
      SHORT_DONE,
      CORE_RST,
      KEYSCHED,
`ifdef RC4_DROP_EN
      DROP,
`endif
      STREAM,
      DRAIN,
      FINISH
   } state_t;

   state_t      state, state_nxt;
   logic        alive, rst_cnt, pend;
   logic [15:0] msg_len, gen_cnt, in_cnt;
   logic [7:0]  fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] fifo_count;
   logic        fifo_empty, fifo_full, cfg_bad, start_ok;
   logic        push, pop, ks_lost, flush, gen_room;
`ifdef RC4_DROP_EN
   logic [15:0] drop_cnt;
`endif

   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == FULL_LVL);
   assign cfg_bad    = (cfg_key_len == 8'd0) || (cfg_key_len > 8'd4);
   assign start_ok   = (state == IDLE) && cmd_start;
   assign pop        = s_valid && s_ready;
   // pend marks a strobe already requested last cycle, so the final enable
   // never asks the core for one byte more than the message needs
   assign gen_room   = ({1'b0, gen_cnt} + {16'd0, pend}) < {1'b0, msg_len};

   // Next-state and per-state control outputs
   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      done       = 1'b0;
      core_start = 1'b0;
      core_ks_en = 1'b0;
      core_rst_n = alive;
      s_ready    = 1'b0;
      push       = 1'b0;
      ks_lost    = 1'b0;
      flush      = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_start)
               state_nxt = (cfg_bad || cfg_msg_len == 16'd0) ? SHORT_DONE : CORE_RST;
         end
         SHORT_DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         CORE_RST: begin
            busy       = 1'b1;
            core_rst_n = 1'b0;
            flush      = 1'b1;
            if (rst_cnt) state_nxt = KEYSCHED;
         end
         KEYSCHED: begin
            busy       = 1'b1;
            core_start = 1'b1;
            if (core_ks_valid) begin
`ifdef RC4_DROP_EN
               state_nxt = DROP;
`else
               push      = 1'b1;
               state_nxt = STREAM;
`endif
            end
         end
`ifdef RC4_DROP_EN
         DROP: begin
            busy       = 1'b1;
            core_ks_en = ({1'b0, drop_cnt} + {16'd0, pend}) < 17'(DROP_N);
            if (drop_cnt == 16'(DROP_N)) state_nxt = STREAM;
         end
`endif
         STREAM: begin
            busy       = 1'b1;
            core_ks_en = (fifo_count < EN_LVL) && gen_room;
            s_ready    = !fifo_empty && (!m_valid || m_ready) && (in_cnt < msg_len);
            if (core_ks_valid) begin
               if (!fifo_full && gen_cnt < msg_len) push = 1'b1;
               else ks_lost = 1'b1;
            end
            if (in_cnt == msg_len) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (!m_valid || m_ready) state_nxt = FINISH;
         end
         FINISH: begin
            done       = 1'b1;
            core_rst_n = 1'b0;
            flush      = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register, two-cycle core-reset counter, post-reset core enable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rst_cnt <= 1'b0;
         alive   <= 1'b0;
      end else begin
         state   <= state_nxt;
         alive   <= 1'b1;
         rst_cnt <= (state == CORE_RST) ? ~rst_cnt : 1'b0;
      end
   end

   // Configuration latch and sticky error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         msg_len      <= '0;
         core_key     <= '0;
         core_key_len <= '0;
         err          <= 1'b0;
      end else if (start_ok) begin
         msg_len <= cfg_msg_len;
         err     <= cfg_bad;
         if (!cfg_bad && cfg_msg_len != 16'd0) begin
            core_key     <= cfg_key;
            core_key_len <= cfg_key_len;
         end
      end else if (ks_lost) begin
         err <= 1'b1;
      end
   end

   // Keystream FIFO storage
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= core_ks_byte;
   end

   // Keystream FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // Byte counters and in-flight strobe tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gen_cnt  <= '0;
         in_cnt   <= '0;
         pend     <= 1'b0;
`ifdef RC4_DROP_EN
         drop_cnt <= '0;
`endif
      end else begin
         pend <= core_ks_en;
         if (flush) begin
            gen_cnt  <= '0;
            in_cnt   <= '0;
`ifdef RC4_DROP_EN
            drop_cnt <= '0;
`endif
         end else begin
            if (push) gen_cnt <= gen_cnt + 16'd1;
            if (pop)  in_cnt  <= in_cnt + 16'd1;
`ifdef RC4_DROP_EN
            if (core_ks_valid && (state == KEYSCHED || state == DROP))
               drop_cnt <= drop_cnt + 16'd1;
`endif
         end
      end
   end

   // Ciphertext output register, held until accepted downstream
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (pop) begin
         m_valid <= 1'b1;
         m_data  <= s_data ^ fifo_mem[rd_ptr];
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end
endmodule
